seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Downstream consumer of the digit/calculator stage: takes four BCD/hex digit codes and time-multiplexes them onto the Basys3 4-digit common-anode display.
- Drives active-low segments, decimal point and anodes.
- Double-buffers the digit value so the display never tears mid-frame.
- Inserts a per-slot anode-off guard interval to suppress ghosting.

Parameters:
- TICK_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range 4..2^20.
- BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must be < TICK_DIV.

Ports:
- clk_in  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- digits_in  input  16  four 4-bit codes; [3:0]=digit 0 (rightmost) … [15:12]=digit 3 (leftmost)
- dp_in  input  4  decimal point request per digit, active-high, same indexing
- load  input  1  single-cycle strobe; captures digits_in/dp_in into the shadow register
- lz_blank  input  1  1 = suppress leading zeros
- seg  output  7  segment cathodes, active-low, bit order gfedcba
- dp  output  1  decimal-point cathode, active-low
- an  output  4  anodes, active-low, an[i] selects digit i
- frame_start  output  1  one-cycle pulse when slot index wraps 3->0

Behaviour:
- Reset (async assert, sync release): an=4'b1111, seg=7'b1111111, dp=1, frame_start=0, slot counter=0, idx=0, shadow=0, active=0, pend=0.
- Slot counter cnt counts 0..TICK_DIV-1. At cnt==TICK_DIV-1: cnt<=0 and idx<=idx+1 mod 4.
- frame_start=1 in the cycle after the idx transition 3->0 (registered).
- Buffering:
  - load=1: shadow<=digits_in/dp_in, pend<=1.
  - At the frame boundary (cnt==TICK_DIV-1 and idx==3), if pend: active<=shadow (value held before this cycle), pend<=0.
  - Simultaneous load and boundary: the old shadow transfers and the new data is captured with pend left at 1; the new data shows one frame later.
  - Multiple loads within a frame: last one wins.
- Output stage: registered, 1-cycle latency from (cnt, idx, active).
  - cnt<BLANK_CYC: an=4'b1111, seg=7'b1111111, dp=1.
  - Otherwise: an = one-hot-low of idx; seg = decode(active digit idx); dp = ~active dp bit idx.
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10-15: see Optional Feature.
- Leading-zero blanking, when lz_blank=1:
  - Digit i (i=3,2,1) is blanked (seg=7'b1111111) if its code and the codes of all digits above it are 0.
  - Digit 0 is never blanked.
  - A set dp on a blanked digit is still driven.
  - lz_blank is sampled live, not buffered.
- An anode is never low during the guard interval. Exactly one anode is low outside it.
- Reset mid-frame: outputs return to reset values immediately and the displayed value reverts to 0. A pending load is discarded.

Optional Feature:
- Macro SEG_HEX_EN.
- Defined: codes 10-15 decode as hex A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Undefined: codes 10-15 decode as blank 7'b1111111.
- Leading-zero logic and everything else are unchanged in both cases.

Test Plan (TICK_DIV=8, BLANK_CYC=2):
- Reset release, no load -> an cycles 1110,1101,1011,0111 with 6 lit cycles per slot, seg=1000000 when lit, dp=1; frame_start pulses every 32 cycles.
- load with digits_in=16'h1234, dp_in=4'b0100 mid-frame -> no change until the next frame_start. Then: digit 3 shows 1111001, digit 0 shows 0011001, dp=0 only while an=1011.
- load at the exact boundary cycle after an earlier load of 16'h0009 -> next frame shows 0009; 16'h… captured at the boundary appears one frame later.
- lz_blank=1, active 16'h0050 -> digits 3,2 blank; digit 1 shows 0010010; digit 0 shows 1000000. With 16'h0000, only digit 0 is lit.
- Code 4'hB with SEG_HEX_EN -> 0000011; without it -> 1111111.
- Assert reset_n=0 mid-slot -> an=1111 and seg=1111111 in the same cycle (asynchronous); after release, digit 0 shows 0 and the earlier pending load is lost.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered 4-digit common-anode scan driver with anode guard interval.
// Define SEG_HEX_EN to decode codes 10-15 as hex glyphs; otherwise they show blank.
module seg_scan_driver #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lz_blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_sh_dig, r_act_dig;
  logic [3:0]    r_sh_dp, r_act_dp;
  logic          r_pend, r_fs, r_dp;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          w_wrap, w_bound, w_lit, w_blank;
  logic [3:0]    w_code;
  logic [6:0]    w_dec;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
`ifdef SEG_HEX_EN
      4'd10:   decode = 7'b0001000;
      4'd11:   decode = 7'b0000011;
      4'd12:   decode = 7'b1000110;
      4'd13:   decode = 7'b0100001;
      4'd14:   decode = 7'b0000110;
      default: decode = 7'b0001110;
`else
      default: decode = 7'b1111111;
`endif
    endcase
  endfunction

  always_comb begin
    w_wrap  = r_cnt == CW'(TICK_DIV - 1);
    w_bound = w_wrap && r_idx == 2'd3;
    w_lit   = r_cnt >= CW'(BLANK_CYC);
    w_code  = r_act_dig[{r_idx, 2'b00} +: 4];
    w_dec   = decode(w_code);
    // a digit blanks only when it and every digit to its left are zero
    w_blank = lz_blank && (r_idx == 2'd3 ? r_act_dig[15:12] == 4'd0 :
                           r_idx == 2'd2 ? r_act_dig[15:8]  == 8'd0 :
                           r_idx == 2'd1 ? r_act_dig[15:4]  == 12'd0 : 1'b0);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_sh_dig  <= 16'd0;
      r_sh_dp   <= 4'd0;
      r_act_dig <= 16'd0;
      r_act_dp  <= 4'd0;
      r_pend    <= 1'b0;
      r_fs      <= 1'b0;
      r_an      <= 4'hf;
      r_seg     <= 7'h7f;
      r_dp      <= 1'b1;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_idx <= r_idx + 1'b1;
      r_fs <= w_bound;
      if (w_bound && r_pend) begin
        r_act_dig <= r_sh_dig;
        r_act_dp  <= r_sh_dp;
      end
      if (load) begin
        r_sh_dig <= digits_in;
        r_sh_dp  <= dp_in;
        r_pend   <= 1'b1;
      end else if (w_bound) begin
        r_pend <= 1'b0;
      end
      r_an  <= w_lit ? ~(4'b0001 << r_idx) : 4'hf;
      r_seg <= w_lit ? (w_blank ? 7'h7f : w_dec) : 7'h7f;
      r_dp  <= w_lit ? ~r_act_dp[r_idx] : 1'b1;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_fs;
endmodule
